// File: rtl/multi_cycle_control_fsm.sv
// Multicycle ARM controller: sequences fetch/decode/execute over a shared ALU and memory.
// Optional MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready.
module multi_cycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [3:0]         cond,
    input  logic [3:0]         alu_flags,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               adr_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic [2:0]         alu_ctl,
    output logic [3:0]         flags,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXECR  = STATE_W'(6),
        EXECI  = STATE_W'(7),
        ALUWB  = STATE_W'(8),
        BRANCH = STATE_W'(9)
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

`ifdef MEM_WAIT_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic [3:0] flags_reg, flags_next;
    logic       cond_ok;
    logic       mem_ok;
    logic       i_bit, s_bit, rd_pc;
    logic [2:0] dp_alu_ctl;
    logic       dp_writes;

    assign mem_ok    = mem_ready | ~WAIT_EN;
    assign i_bit     = funct[5];
    assign s_bit     = funct[0];
    assign rd_pc     = (rd == 4'd15);
    assign flags     = flags_reg;
    assign dbg_state = state_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
            flags_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            flags_reg <= flags_next;
        end
    end

    // Condition evaluated against the flag register as it stands this cycle (N,Z,C,V = [3:0]).
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags_reg[2];
            4'b0001: cond_ok = ~flags_reg[2];
            4'b0010: cond_ok = flags_reg[1];
            4'b0011: cond_ok = ~flags_reg[1];
            4'b0100: cond_ok = flags_reg[3];
            4'b0101: cond_ok = ~flags_reg[3];
            4'b0110: cond_ok = flags_reg[0];
            4'b0111: cond_ok = ~flags_reg[0];
            4'b1000: cond_ok = flags_reg[1] & ~flags_reg[2];
            4'b1001: cond_ok = ~flags_reg[1] | flags_reg[2];
            4'b1010: cond_ok = ~(flags_reg[3] ^ flags_reg[0]);
            4'b1011: cond_ok = flags_reg[3] ^ flags_reg[0];
            4'b1100: cond_ok = ~flags_reg[2] & ~(flags_reg[3] ^ flags_reg[0]);
            4'b1101: cond_ok = flags_reg[2] | (flags_reg[3] ^ flags_reg[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // CMP computes a SUB for its flags only; unknown commands fall back to ADD with no writeback.
    always_comb begin
        dp_alu_ctl = ALU_ADD;
        dp_writes  = 1'b0;
        case (funct[4:1])
            4'b0100: begin dp_alu_ctl = ALU_ADD; dp_writes = 1'b1; end
            4'b0010: begin dp_alu_ctl = ALU_SUB; dp_writes = 1'b1; end
            4'b0000: begin dp_alu_ctl = ALU_AND; dp_writes = 1'b1; end
            4'b1100: begin dp_alu_ctl = ALU_ORR; dp_writes = 1'b1; end
            4'b1010: dp_alu_ctl = ALU_SUB;
            default: dp_alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        flags_next = flags_reg;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        reg_src    = 2'b00;
        alu_ctl    = ALU_ADD;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        case (state_reg)
            FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ok) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = i_bit ? EXECI : EXECR;
                    2'b10:   state_next = BRANCH;
                    default: begin
                        state_next = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b01;
                state_next = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src    = 1'b1;
                state_next = mem_ok ? MEMWB : MEMRD;
            end
            MEMWB, ALUWB: begin
                result_src = (state_reg == MEMWB) ? 2'b01 : 2'b00;
                // A write to r15 is steered into the PC instead of the register file.
                reg_write  = cond_ok & ~rd_pc;
                pc_write   = cond_ok & rd_pc;
                state_next = FETCH;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                reg_src    = 2'b10;
                mem_write  = cond_ok;
                state_next = mem_ok ? FETCH : MEMWR;
            end
            EXECR, EXECI: begin
                alu_src_b  = (state_reg == EXECI) ? 2'b01 : 2'b00;
                alu_ctl    = dp_alu_ctl;
                if (s_bit && cond_ok) begin
                    flags_next = alu_flags;
                end
                state_next = dp_writes ? ALUWB : FETCH;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = cond_ok;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        instr_done = (state_next == FETCH) && (state_reg != FETCH);

        // Writes must vanish the moment reset asserts, not at the next edge.
        if (!reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Self-checking bench for multi_cycle_control_fsm: directed instructions, then random ones,
// each compared cycle by cycle against an instruction-level trace model.
module tb_multi_cycle_control_fsm;

    localparam int STATE_W = 4;

`ifdef MEM_WAIT_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         op = 2'b00;
    logic [5:0]         funct = 6'b0;
    logic [3:0]         rd = 4'd0;
    logic [3:0]         cond = 4'b1110;
    logic [3:0]         alu_flags = 4'b0;
    logic               mem_ready = 1'b1;
    logic               pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0]         alu_src_a, alu_src_b, result_src, imm_src, reg_src;
    logic [2:0]         alu_ctl;
    logic [3:0]         flags;
    logic               instr_done, illegal_op;
    logic [STATE_W-1:0] dbg_state;

    multi_cycle_control_fsm #(.STATE_W(STATE_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl),
        .flags(flags), .instr_done(instr_done), .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy, pcw, irw, rw, mw, done, ill, chk_alu;
        logic [2:0] alu;
        logic [3:0] flg;
    } step_t;

    step_t      tr[$];
    logic [3:0] mflags = 4'b0;
    int         total = 0;
    int         bad = 0;
    int         ninstr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ARM condition table: pairs of codes share a predicate, odd code inverts it.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic logic ready_bit();
        return WAITS ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic step_t mk(input int st);
        step_t s;
        s.st = 4'(st); s.rdy = 1'($urandom_range(0, 1));
        s.pcw = 0; s.irw = 0; s.rw = 0; s.mw = 0; s.done = 0; s.ill = 0;
        s.chk_alu = 0; s.alu = 3'b000; s.flg = mflags;
        return s;
    endfunction

    // Expected per-cycle trace of one instruction; advances mflags as the flag register would.
    task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                         input logic [3:0] c, input logic [3:0] af, input int fw_in, input int mw_in);
        step_t s;
        logic ok, wb;
        int fw, mw;
        fw = WAITS ? fw_in : 0;
        mw = WAITS ? mw_in : 0;
        tr.delete();
        for (int k = 0; k < fw; k++) begin
            s = mk(0); s.rdy = 0; tr.push_back(s);
        end
        s = mk(0); s.rdy = ready_bit(); s.pcw = 1; s.irw = 1; tr.push_back(s);
        s = mk(1);
        if (o == 2'b11) begin
            s.done = 1; s.ill = 1; tr.push_back(s);
            return;
        end
        tr.push_back(s);
        ok = cond_holds(c, mflags);
        case (o)
            2'b01: begin
                s = mk(2); s.chk_alu = 1; s.alu = 3'b000; tr.push_back(s);
                if (f[0]) begin
                    for (int k = 0; k < mw; k++) begin
                        s = mk(3); s.rdy = 0; tr.push_back(s);
                    end
                    s = mk(3); s.rdy = ready_bit(); tr.push_back(s);
                    s = mk(4); s.rw = ok && (r != 15); s.pcw = ok && (r == 15); s.done = 1;
                    tr.push_back(s);
                end else begin
                    for (int k = 0; k < mw; k++) begin
                        s = mk(5); s.rdy = 0; s.mw = ok; tr.push_back(s);
                    end
                    s = mk(5); s.rdy = ready_bit(); s.mw = ok; s.done = 1; tr.push_back(s);
                end
            end
            2'b00: begin
                s = mk(f[5] ? 7 : 6); s.chk_alu = 1; wb = 1;
                case (f[4:1])
                    4'd4:  s.alu = 3'b000;
                    4'd2:  s.alu = 3'b001;
                    4'd0:  s.alu = 3'b010;
                    4'd12: s.alu = 3'b011;
                    4'd10: begin s.alu = 3'b001; wb = 0; end
                    default: begin s.alu = 3'b000; wb = 0; end
                endcase
                s.done = !wb;
                tr.push_back(s);
                if (f[0] && ok) mflags = af;
                if (wb) begin
                    ok = cond_holds(c, mflags);
                    s = mk(8); s.rw = ok && (r != 15); s.pcw = ok && (r == 15); s.done = 1;
                    tr.push_back(s);
                end
            end
            default: begin
                s = mk(9); s.pcw = ok; s.done = 1; tr.push_back(s);
            end
        endcase
    endtask

    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] c, input logic [3:0] af, input int fw,
                             input int mw, input bit abort_last);
        string t;
        build(o, f, r, c, af, fw, mw);
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            op = o; funct = f; rd = r; cond = c; alu_flags = af;
            mem_ready = tr[i].rdy;
            #1;
            t = $sformatf("i%0d.c%0d", ninstr, i);
            chk({t, ".state"}, 32'(dbg_state), 32'(tr[i].st));
            chk({t, ".pc_write"}, 32'(pc_write), 32'(tr[i].pcw));
            chk({t, ".ir_write"}, 32'(ir_write), 32'(tr[i].irw));
            chk({t, ".reg_write"}, 32'(reg_write), 32'(tr[i].rw));
            chk({t, ".mem_write"}, 32'(mem_write), 32'(tr[i].mw));
            chk({t, ".instr_done"}, 32'(instr_done), 32'(tr[i].done));
            chk({t, ".illegal_op"}, 32'(illegal_op), 32'(tr[i].ill));
            chk({t, ".flags"}, 32'(flags), 32'(tr[i].flg));
            if (tr[i].chk_alu) chk({t, ".alu_ctl"}, 32'(alu_ctl), 32'(tr[i].alu));
            if (abort_last && i == tr.size() - 1) begin
                reset = 1'b0;
                #1;
                chk({t, ".rst.reg_write"}, 32'(reg_write), 32'(0));
                chk({t, ".rst.pc_write"}, 32'(pc_write), 32'(0));
                chk({t, ".rst.state"}, 32'(dbg_state), 32'(0));
                chk({t, ".rst.flags"}, 32'(flags), 32'(0));
                mflags = 4'b0;
            end
        end
        ninstr++;
    endtask

    initial begin
        logic [1:0] ro;
        logic [3:0] rc;

        // Reset held with mem_ready high: nothing may be written.
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d.state", k), 32'(dbg_state), 32'(0));
            chk($sformatf("rst%0d.flags", k), 32'(flags), 32'(0));
            chk($sformatf("rst%0d.pc_write", k), 32'(pc_write), 32'(0));
            chk($sformatf("rst%0d.ir_write", k), 32'(ir_write), 32'(0));
            chk($sformatf("rst%0d.reg_write", k), 32'(reg_write), 32'(0));
            chk($sformatf("rst%0d.mem_write", k), 32'(mem_write), 32'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD r1,r2,#5
        run_instr(2'b00, 6'b101000, 4'd1, 4'b1110, 4'b0000, 0, 0, 0);
        // CMP setting Z, then BEQ taken and BNE not taken
        run_instr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100, 0, 0, 0);
        run_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000, 0, 0, 0);
        run_instr(2'b10, 6'b100000, 4'd0, 4'b0001, 4'b0000, 0, 0, 0);
        // LDR with two wait cycles, STR with one
        run_instr(2'b01, 6'b011001, 4'd3, 4'b1110, 4'b0000, 0, 2, 0);
        run_instr(2'b01, 6'b011000, 4'd3, 4'b1110, 4'b0000, 0, 1, 0);
        // Illegal opcode
        run_instr(2'b11, 6'b000000, 4'd2, 4'b1110, 4'b0000, 0, 0, 0);
        // Load to r15 goes to the PC
        run_instr(2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000, 1, 0, 0);

        for (int n = 0; n < 200; n++) begin
            ro = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 1) == 1) ? 4'b1110 : 4'($urandom);
            run_instr(ro, 6'($urandom), 4'($urandom), rc, 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        // ADDS then reset asserted during ALUWB
        run_instr(2'b00, 6'b101001, 4'd4, 4'b1110, 4'b1010, 0, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(2'b00, 6'b000001, 4'd5, 4'b1110, 4'b0110, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
